// File: rtl/pe2ddr.sv
// -----------------------------------------------------------------------------
// pe2ddr
//
// Drains PE result buffers to DDR as a series of bursts. One burst k reads
// from PE (pe_st + k) mod PE_NUM and sends conf_burst beats. Each DDR beat is
// assembled from four consecutive buffer reads (lanes 0..3), packed with lane 0
// in the least significant slice. Burst k is written to DDR address
// conf_ddr_addr + k*conf_step.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle job request, accepted only while busy is low
//   busy                job in progress (from the cycle after accept through FIN)
//   done                one-cycle pulse in the last cycle of a job
//   conf_*              job configuration, latched when start is accepted
//   rbuf_rd_addr        buffer read address, shared by all PEs
//   rbuf_rd_en          one-hot per-PE read enable
//   rbuf_rd_data        per-PE read data, valid one cycle after the enable
//   ddr_addr/size/addr_valid, ddr_addr_ready   DDR write-address channel
//   ddr_data/last/valid, ddr_ready             DDR write-data channel
//
// BUF_DEPTH is expected to be a power of two: buffer addresses wrap by
// truncation to ADDR_W bits.
// -----------------------------------------------------------------------------
module pe2ddr #(
    parameter int BUF_DEPTH  = 256,
    parameter int PE_NUM     = 32,
    parameter int DATA_W     = 8,
    parameter int BATCH      = 4,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8,
    parameter int ADDR_W     = $clog2(BUF_DEPTH),
    parameter int PE_W       = (PE_NUM > 1) ? $clog2(PE_NUM) : 1,
    parameter int LANE_W     = BATCH * DATA_W,
    parameter int DDR_W      = 4 * LANE_W
) (
    input  logic                               clk,
    input  logic                               rst,

    input  logic                               start,
    output logic                               busy,
    output logic                               done,

    input  logic [DDR_ADDR_W-1:0]              conf_ddr_addr,
    input  logic [DDR_ADDR_W-1:0]              conf_step,
    input  logic [BURST_W-1:0]                 conf_burst,
    input  logic [BURST_W-1:0]                 conf_burst_num,
    input  logic [PE_W-1:0]                    conf_pe_st,
    input  logic [ADDR_W-1:0]                  conf_buf_addr,

    output logic [ADDR_W-1:0]                  rbuf_rd_addr,
    output logic [PE_NUM-1:0]                  rbuf_rd_en,
    input  logic [PE_NUM-1:0][LANE_W-1:0]      rbuf_rd_data,

    output logic [DDR_ADDR_W-1:0]              ddr_addr,
    output logic [BURST_W-1:0]                 ddr_size,
    output logic                               ddr_addr_valid,
    input  logic                               ddr_addr_ready,

    output logic [DDR_W-1:0]                   ddr_data,
    output logic                               ddr_last,
    output logic                               ddr_valid,
    input  logic                               ddr_ready
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RD,
        CAP,
        SEND,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    // Latched job configuration
    logic [DDR_ADDR_W-1:0] cfg_step;
    logic [BURST_W-1:0]    cfg_burst;
    logic [BURST_W-1:0]    cfg_burst_num;
    logic [ADDR_W-1:0]     cfg_buf_addr;

    // Job progress
    logic [DDR_ADDR_W-1:0] cur_addr;   // DDR address of the current burst
    logic [PE_W-1:0]       pe_idx;     // PE read by the current burst
    logic [BURST_W-1:0]    burst_idx;  // k
    logic [BURST_W-1:0]    beat_idx;   // b
    logic [1:0]            lane;       // lane being read in RD
    logic [DDR_W-1:0]      data_q;

    logic                  start_ok;
    logic                  zero_job;
    logic                  last_beat;
    logic                  last_burst;
    logic                  cap_en;
    logic [1:0]            cap_lane;
    logic [ADDR_W-1:0]     rd_addr_calc;

    assign start_ok   = start && (state == IDLE);
    assign zero_job   = (conf_burst == '0) || (conf_burst_num == '0);
    assign last_beat  = (beat_idx == cfg_burst - BURST_W'(1));
    assign last_burst = (burst_idx == cfg_burst_num - BURST_W'(1));

    // Buffer address wraps modulo BUF_DEPTH through ADDR_W truncation.
    assign rd_addr_calc = cfg_buf_addr + ADDR_W'({beat_idx, 2'b00}) + ADDR_W'(lane);

    // Read data lags the read by one cycle, so the lane being captured is always
    // lane-1. After lane 3 is read the counter wraps to 0, which makes lane-1
    // equal 3 in CAP without extra state.
    assign cap_en   = ((state == RD) && (lane != 2'd0)) || (state == CAP);
    assign cap_lane = lane - 2'd1;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default at the top of the block so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = zero_job ? FIN : ADDR;
                end
            end
            ADDR: begin
                if (ddr_addr_ready) begin
                    state_next = RD;
                end
            end
            RD: begin
                if (lane == 2'd3) begin
                    state_next = CAP;
                end
            end
            CAP: begin
                state_next = SEND;
            end
            SEND: begin
                if (ddr_ready) begin
                    if (!last_beat) begin
                        state_next = RD;
                    end else if (!last_burst) begin
                        state_next = ADDR;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy           = (state != IDLE);
        done           = (state == FIN);
        ddr_addr_valid = (state == ADDR);
        ddr_valid      = (state == SEND);
        ddr_last       = (state == SEND) && last_beat;
        rbuf_rd_en     = '0;
        rbuf_rd_addr   = '0;
        if (state == RD) begin
            rbuf_rd_en   = {{(PE_NUM-1){1'b0}}, 1'b1} << pe_idx;
            rbuf_rd_addr = rd_addr_calc;
        end
    end

    // Payload registers only change outside ADDR/SEND, so they stay stable
    // while the matching valid waits for its ready.
    assign ddr_addr = cur_addr;
    assign ddr_size = cfg_burst;
    assign ddr_data = data_q;

    // -------------------------------------------------------------------------
    // Datapath: configuration, counters and beat assembly
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, independent of ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_step      <= '0;
            cfg_burst     <= '0;
            cfg_burst_num <= '0;
            cfg_buf_addr  <= '0;
            cur_addr      <= '0;
            pe_idx        <= '0;
            burst_idx     <= '0;
            beat_idx      <= '0;
            lane          <= '0;
            data_q        <= '0;
        end else begin
            if (start_ok) begin
                cfg_step      <= conf_step;
                cfg_burst     <= conf_burst;
                cfg_burst_num <= conf_burst_num;
                cfg_buf_addr  <= conf_buf_addr;
                cur_addr      <= conf_ddr_addr;
                pe_idx        <= conf_pe_st;
                burst_idx     <= '0;
                beat_idx      <= '0;
                lane          <= '0;
            end

            if (state == RD) begin
                lane <= lane + 2'd1;
            end

            if (cap_en) begin
                data_q[cap_lane*LANE_W +: LANE_W] <= rbuf_rd_data[pe_idx];
            end

            if ((state == SEND) && ddr_ready) begin
                if (last_beat) begin
                    beat_idx  <= '0;
                    burst_idx <= burst_idx + BURST_W'(1);
                    cur_addr  <= cur_addr + cfg_step;
                    pe_idx    <= (pe_idx == PE_W'(PE_NUM - 1)) ? '0 : pe_idx + PE_W'(1);
                end else begin
                    beat_idx <= beat_idx + BURST_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pe2ddr.sv
// -----------------------------------------------------------------------------
// tb_pe2ddr
//
// Buffers are filled with random words. For each job the expected address,
// read and beat streams are computed directly from the job description
// (burst k at base + k*step reading PE (pe_st+k) mod PE_NUM, beat b built from
// buffer words buf + 4b + l), then compared against what a negedge monitor saw
// on the DUT's handshakes.
// -----------------------------------------------------------------------------
module tb_pe2ddr;

    localparam int BUF_DEPTH  = 256;
    localparam int PE_NUM     = 32;
    localparam int DATA_W     = 8;
    localparam int BATCH      = 4;
    localparam int DDR_ADDR_W = 32;
    localparam int BURST_W    = 8;
    localparam int ADDR_W     = 8;
    localparam int PE_W       = 5;
    localparam int LANE_W     = BATCH * DATA_W;
    localparam int DDR_W      = 4 * LANE_W;
    localparam int WAIT_LIMIT = 20000;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          start;
    logic                          busy;
    logic                          done;
    logic [DDR_ADDR_W-1:0]         conf_ddr_addr;
    logic [DDR_ADDR_W-1:0]         conf_step;
    logic [BURST_W-1:0]            conf_burst;
    logic [BURST_W-1:0]            conf_burst_num;
    logic [PE_W-1:0]               conf_pe_st;
    logic [ADDR_W-1:0]             conf_buf_addr;
    logic [ADDR_W-1:0]             rbuf_rd_addr;
    logic [PE_NUM-1:0]             rbuf_rd_en;
    logic [PE_NUM-1:0][LANE_W-1:0] rbuf_rd_data;
    logic [DDR_ADDR_W-1:0]         ddr_addr;
    logic [BURST_W-1:0]            ddr_size;
    logic                          ddr_addr_valid;
    logic                          ddr_addr_ready = 1'b0;
    logic [DDR_W-1:0]              ddr_data;
    logic                          ddr_last;
    logic                          ddr_valid;
    logic                          ddr_ready = 1'b0;

    pe2ddr #(
        .BUF_DEPTH (BUF_DEPTH),
        .PE_NUM    (PE_NUM),
        .DATA_W    (DATA_W),
        .BATCH     (BATCH),
        .DDR_ADDR_W(DDR_ADDR_W),
        .BURST_W   (BURST_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .conf_ddr_addr (conf_ddr_addr),
        .conf_step     (conf_step),
        .conf_burst    (conf_burst),
        .conf_burst_num(conf_burst_num),
        .conf_pe_st    (conf_pe_st),
        .conf_buf_addr (conf_buf_addr),
        .rbuf_rd_addr  (rbuf_rd_addr),
        .rbuf_rd_en    (rbuf_rd_en),
        .rbuf_rd_data  (rbuf_rd_data),
        .ddr_addr      (ddr_addr),
        .ddr_size      (ddr_size),
        .ddr_addr_valid(ddr_addr_valid),
        .ddr_addr_ready(ddr_addr_ready),
        .ddr_data      (ddr_data),
        .ddr_last      (ddr_last),
        .ddr_valid     (ddr_valid),
        .ddr_ready     (ddr_ready)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------ checks
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DDR_W:0] obs, input logic [DDR_W:0] exp);
        n_checks++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ------------------------------------------------------------ buffer model
    // Disabled PEs return the complement of their word, so a wrong enable
    // shows up as wrong beat data.
    logic [LANE_W-1:0] mem [PE_NUM][BUF_DEPTH];

    always @(posedge clk) begin
        for (int p = 0; p < PE_NUM; p++) begin
            rbuf_rd_data[p] <= rbuf_rd_en[p] ? mem[p][rbuf_rd_addr] : ~mem[p][rbuf_rd_addr];
        end
    end

    // ----------------------------------------------------------- ready driver
    // 0: always ready; 1: random; 2: addr ready after 3 low cycles, data ready
    // after 5 low cycles; 3: data never ready.
    int rmode   = 0;
    int aw_wait = 0;
    int w_wait  = 0;

    always @(posedge clk) begin
        #1;
        aw_wait = ddr_addr_valid ? aw_wait + 1 : 0;
        w_wait  = ddr_valid ? w_wait + 1 : 0;
        case (rmode)
            0: begin ddr_addr_ready = 1'b1; ddr_ready = 1'b1; end
            1: begin
                ddr_addr_ready = 1'($urandom_range(0, 1));
                ddr_ready      = 1'($urandom_range(0, 1));
            end
            2: begin ddr_addr_ready = (aw_wait > 3); ddr_ready = (w_wait > 5); end
            default: begin ddr_addr_ready = 1'b1; ddr_ready = 1'b0; end
        endcase
    end

    // ----------------------------------------------------------------- monitor
    logic [DDR_ADDR_W+BURST_W-1:0] got_aw[$], exp_aw[$];
    logic [DDR_W:0]                got_w[$],  exp_w[$];
    int                            got_rd[$], exp_rd[$];
    int                            done_cnt = 0;

    logic                          aw_hold = 1'b0;
    logic [DDR_ADDR_W+BURST_W-1:0] aw_prev;
    logic                          w_hold = 1'b0;
    logic [DDR_W:0]                w_prev;

    always @(negedge clk) begin
        if (rst) begin
            aw_hold = 1'b0;
            w_hold  = 1'b0;
        end else begin
            if (aw_hold) check("aw_stable", {ddr_addr_valid, ddr_addr, ddr_size}, {1'b1, aw_prev});
            if (w_hold)  check("w_stable", {ddr_valid, ddr_last, ddr_data}, {1'b1, w_prev});
            if (ddr_addr_valid && ddr_addr_ready) got_aw.push_back({ddr_addr, ddr_size});
            if (ddr_valid && ddr_ready) got_w.push_back({ddr_last, ddr_data});
            aw_hold = ddr_addr_valid && !ddr_addr_ready;
            aw_prev = {ddr_addr, ddr_size};
            w_hold  = ddr_valid && !ddr_ready;
            w_prev  = {ddr_last, ddr_data};
            if (rbuf_rd_en != '0) begin
                int idx = 0;
                check("rd_en_onehot", $onehot(rbuf_rd_en), 1);
                for (int p = 0; p < PE_NUM; p++) if (rbuf_rd_en[p]) idx = p;
                got_rd.push_back(idx * BUF_DEPTH + int'(rbuf_rd_addr));
            end
            if (done) done_cnt++;
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic clear_queues();
        got_aw.delete(); got_w.delete(); got_rd.delete();
        exp_aw.delete(); exp_w.delete(); exp_rd.delete();
        done_cnt = 0;
    endtask

    task automatic randomize_conf();
        conf_ddr_addr  = $urandom;
        conf_step      = $urandom;
        conf_burst     = BURST_W'($urandom);
        conf_burst_num = BURST_W'($urandom);
        conf_pe_st     = PE_W'($urandom);
        conf_buf_addr  = ADDR_W'($urandom);
    endtask

    task automatic compare_queues(input string tag);
        check({tag, "_aw_count"}, got_aw.size(), exp_aw.size());
        for (int i = 0; i < got_aw.size() && i < exp_aw.size(); i++)
            check($sformatf("%s_aw%0d", tag, i), got_aw[i], exp_aw[i]);
        check({tag, "_rd_count"}, got_rd.size(), exp_rd.size());
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
            check($sformatf("%s_rd%0d", tag, i), got_rd[i], exp_rd[i]);
        check({tag, "_w_count"}, got_w.size(), exp_w.size());
        for (int i = 0; i < got_w.size() && i < exp_w.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got_w[i], exp_w[i]);
    endtask

    // Runs one job end to end. poke raises start again in the cycle after
    // acceptance (ADDR, or FIN for an empty job); it must be ignored.
    task automatic run_job(input string tag,
                           input logic [DDR_ADDR_W-1:0] base, input logic [DDR_ADDR_W-1:0] step,
                           input int burst, input int bnum, input int pe_st, input int buf_a,
                           input int mode, input bit poke);
        int cyc;
        logic [DDR_W-1:0] d;
        clear_queues();
        for (int k = 0; k < bnum && burst != 0; k++) begin
            int pe = (pe_st + k) % PE_NUM;
            exp_aw.push_back({base + step * k, BURST_W'(burst)});
            for (int b = 0; b < burst; b++) begin
                for (int l = 0; l < 4; l++) begin
                    int ad = (buf_a + 4 * b + l) % BUF_DEPTH;
                    exp_rd.push_back(pe * BUF_DEPTH + ad);
                    d[l*LANE_W +: LANE_W] = mem[pe][ad];
                end
                exp_w.push_back({(b == burst - 1), d});
            end
        end
        rmode = mode;
        @(posedge clk); #2;
        conf_ddr_addr  = base;
        conf_step      = step;
        conf_burst     = BURST_W'(burst);
        conf_burst_num = BURST_W'(bnum);
        conf_pe_st     = PE_W'(pe_st);
        conf_buf_addr  = ADDR_W'(buf_a);
        start          = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        randomize_conf();
        check({tag, "_busy_rise"}, busy, 1'b1);
        if (poke) begin
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < WAIT_LIMIT) begin
            @(posedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, (done_cnt != 0), 1'b1);
        #2;
        check({tag, "_busy_fall"}, busy, 1'b0);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_busy_idle"}, busy, 1'b0);
        compare_queues(tag);
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        randomize_conf();
        for (int p = 0; p < PE_NUM; p++)
            for (int a = 0; a < BUF_DEPTH; a++)
                mem[p][a] = $urandom;

        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd_en", rbuf_rd_en, '0);
        check("rst_rd_addr", rbuf_rd_addr, '0);
        check("rst_valids", {ddr_addr_valid, ddr_valid, ddr_last}, 3'b000);
        check("rst_payload", {ddr_addr, ddr_size}, '0);
        check("rst_data", ddr_data, '0);
        @(negedge clk);
        rst = 1'b0;

        run_job("single", 32'h1000_0000, 32'h0, 1, 1, 3, 10, 0, 1'b0);
        run_job("multi", 32'hABCD_0000, 32'h40, 2, 3, 31, int'($urandom_range(0, 255)), 0, 1'b1);
        run_job("bp", $urandom, $urandom, 3, 2, int'($urandom_range(0, 31)),
                int'($urandom_range(0, 255)), 2, 1'b0);
        run_job("wrap", $urandom, $urandom, 1, 1, int'($urandom_range(0, 31)), 254, 0, 1'b0);
        run_job("zero_bnum", $urandom, $urandom, 4, 0, 5, 7, 0, 1'b1);
        run_job("zero_burst", $urandom, $urandom, 0, 3, 5, 7, 0, 1'b0);

        // Reset while a beat is stuck in SEND.
        clear_queues();
        rmode = 3;
        @(posedge clk); #2;
        conf_ddr_addr  = 32'h2000;
        conf_step      = 32'h100;
        conf_burst     = 8'd4;
        conf_burst_num = 8'd2;
        conf_pe_st     = 5'd7;
        conf_buf_addr  = 8'd20;
        start          = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        cyc = 0;
        while (!ddr_valid && cyc < WAIT_LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_send_reached", ddr_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy_done", {busy, done}, 2'b00);
        check("mid_rst_rd", {rbuf_rd_en, rbuf_rd_addr}, '0);
        check("mid_rst_valids", {ddr_addr_valid, ddr_valid, ddr_last}, 3'b000);
        check("mid_rst_payload", {ddr_addr, ddr_size}, '0);
        check("mid_rst_data", ddr_data, '0);
        rmode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_queues();
        repeat (12) @(negedge clk);
        compare_queues("post_rst_quiet");
        check("post_rst_busy", busy, 1'b0);
        run_job("post_rst", $urandom, $urandom, 2, 2, int'($urandom_range(0, 31)),
                int'($urandom_range(0, 255)), 0, 1'b0);

        // Random jobs with random handshakes.
        for (int j = 0; j < 8; j++) begin
            run_job($sformatf("rand%0d", j), $urandom, $urandom,
                    int'($urandom_range(1, 6)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pe2ddr.md
PE2DDR -- requirements
Module: pe2ddr

Interface
REQ-001 SHALL have parameter BUF_DEPTH, default 256, depth of each PE result buffer.
REQ-002 SHALL have parameter PE_NUM, default 32, number of PE buffers.
REQ-003 SHALL have parameter ADDR_W, default bw(BUF_DEPTH), buffer address width; DATA_W, BATCH, DDR_W (=4*BATCH*DATA_W), DDR_ADDR_W, BURST_W come from GLOBAL_PARAM.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; ports named clk and rst.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  one-cycle job request.
REQ-008 busy  output  1  job in progress; start ignored while high.
REQ-009 done  output  1  one-cycle pulse at job end.
REQ-010 conf_ddr_addr  input  DDR_ADDR_W  DDR start address of burst 0.
REQ-011 conf_step  input  DDR_ADDR_W  DDR address increment per burst.
REQ-012 conf_burst  input  BURST_W  beats per burst.
REQ-013 conf_burst_num  input  BURST_W  number of bursts.
REQ-014 conf_pe_st  input  bw(PE_NUM)  PE index read by burst 0.
REQ-015 conf_buf_addr  input  ADDR_W  first buffer address read in every burst.
REQ-016 rbuf_rd_addr  output  ADDR_W  buffer read address, shared by all PEs.
REQ-017 rbuf_rd_en  output  PE_NUM  one-hot read enable.
REQ-018 rbuf_rd_data  input  PE_NUM x BATCH*DATA_W  per-PE read data, valid 1 cycle after rd_en.
REQ-019 ddr_addr / ddr_size / ddr_addr_valid  output  DDR_ADDR_W / BURST_W / 1  write-address channel.
REQ-020 ddr_addr_ready  input  1  address accepted.
REQ-021 ddr_data / ddr_last / ddr_valid  output  DDR_W / 1 / 1  write-data channel.
REQ-022 ddr_ready  input  1  data beat accepted.

Function
REQ-023 All config SHALL be latched when start is accepted (start=1, busy=0); busy SHALL rise the next cycle.
REQ-024 States SHALL be IDLE, ADDR, RD, CAP, SEND, FIN.
REQ-025 IDLE->ADDR on accepted start; IDLE->FIN if conf_burst=0 or conf_burst_num=0 (no DDR traffic).
REQ-026 ADDR: ddr_addr_valid=1, ddr_addr=conf_ddr_addr+k*conf_step (k=burst index, modulo 2^DDR_ADDR_W), ddr_size=conf_burst; on ddr_addr_ready -> RD.
REQ-027 RD: 4 consecutive cycles, lane l=0..3, rbuf_rd_en one-hot at PE (conf_pe_st+k) mod PE_NUM, rbuf_rd_addr = conf_buf_addr + 4*b + l modulo BUF_DEPTH (b=beat index in burst); then -> CAP.
REQ-028 Read data of lane l SHALL be captured into ddr_data bits [l*BATCH*DATA_W +: BATCH*DATA_W] the cycle after its read; CAP captures lane 3, then -> SEND.
REQ-029 SEND: ddr_valid=1, ddr_data held stable; ddr_last=1 iff b=conf_burst-1; stay until ddr_ready.
REQ-030 On SEND handshake: more beats -> RD; last beat, more bursts -> ADDR (k+1); last beat of last burst -> FIN.
REQ-031 FIN: done=1 for exactly one cycle, busy=0 from the next cycle, -> IDLE.
REQ-032 Valid outputs SHALL never drop or change payload before their ready handshake.
REQ-033 rbuf_rd_en SHALL be all zero outside RD; ddr_addr_valid only in ADDR; ddr_valid only in SEND.
REQ-034 Start during busy or FIN SHALL be ignored; new start accepted earliest the cycle after done.

Reset
REQ-035 rst SHALL force IDLE immediately, including mid-job; busy, done, rbuf_rd_en, ddr_addr_valid, ddr_valid, ddr_last =0; ddr_addr, ddr_size, ddr_data, rbuf_rd_addr =0.
REQ-036 After mid-job reset no residual read, address or data beat SHALL be issued; next start runs a clean job.

Verification
REQ-037 Single beat: burst=1, burst_num=1, pe_st=3, buf_addr=10, readies high -> one address (conf_ddr_addr, size 1), reads PE3 addr 10..13, one beat last=1 with lanes in order, done once.
REQ-038 Multi-burst: burst=2, burst_num=3, step=0x40, pe_st=31 -> addresses A, A+0x40, A+0x80; PEs 31, 0, 1; last on beats 2,4,6.
REQ-039 Backpressure: ddr_ready low 5 cycles in SEND, ddr_addr_ready low 3 cycles -> valid and payload held stable, no extra reads, beat count unchanged.
REQ-040 Wrap: buf_addr=254, BUF_DEPTH=256, burst=1 -> read addresses 254, 255, 0, 1.
REQ-041 Zero length: burst_num=0 -> no DDR traffic, done pulse, busy low afterward; start while busy ignored.
REQ-042 Reset mid-SEND -> all outputs zero immediately; subsequent job completes correctly.
